// File: rtl/dcache_pkg.sv
// Shared types and widths for the dcache tag/overhead path.
package dcache_pkg;

  localparam int TAG_WIDTH           = 20;
  localparam int OVERHEAD_ADDR_WIDTH = 6;
  localparam int OFFSET_WIDTH        = 6;
  localparam int DATA_WIDTH          = TAG_WIDTH + 2;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]           tag;
    logic [OVERHEAD_ADDR_WIDTH-1:0] index;
    logic [OFFSET_WIDTH-1:0]        offset;
  } laddr_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } overhead_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } tl_state_e;

endpackage

// File: rtl/dcache_overhead.sv
// Simple dual-port overhead RAM: write port A, synchronous read port B, no reset.
module dcache_overhead
  import dcache_pkg::*;
(
  input  logic                           clk,
  input  logic [OVERHEAD_ADDR_WIDTH-1:0] addra,
  input  logic                           ena,
  input  overhead_t                      dina,
  input  logic [OVERHEAD_ADDR_WIDTH-1:0] addrb,
  input  logic                           enb,
  output overhead_t                      doutb
);

  overhead_t mem [0:(2**OVERHEAD_ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (ena) mem[addra] <= dina;
    if (enb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/dcache_tag_lookup.sv
// Tag lookup control in front of the overhead RAM: invalidate sweep, lookup,
// store-hit dirty update and refill install.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | sweeping every overhead entry to invalid after reset
//   IDLE  | accepting fills (priority) or lookup requests
//   READ  | RAM data valid; compare tag, write dirty on store hit
//   RESP  | holding lookup result until resp_ready
module dcache_tag_lookup
  import dcache_pkg::*;
#(
  parameter int TAG_WIDTH    = dcache_pkg::TAG_WIDTH,
  parameter int INDEX_WIDTH  = dcache_pkg::OVERHEAD_ADDR_WIDTH,
  parameter int OFFSET_WIDTH = dcache_pkg::OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_addr,
  input  logic                   req_we,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic                   resp_victim_valid,
  output logic                   resp_victim_dirty,
  output logic [TAG_WIDTH-1:0]   resp_victim_tag,
  output logic [INDEX_WIDTH-1:0] resp_index,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [INDEX_WIDTH-1:0] fill_index,
  input  logic [TAG_WIDTH-1:0]   fill_tag,
  input  logic                   fill_dirty,
  output logic [INDEX_WIDTH-1:0] oh_addra,
  output logic                   oh_ena,
  output overhead_t              oh_dina,
  output logic [INDEX_WIDTH-1:0] oh_addrb,
  output logic                   oh_enb,
  input  overhead_t              oh_doutb
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

  tl_state_e              state, state_nx;
  logic [INDEX_WIDTH-1:0] sweep_cnt;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [INDEX_WIDTH-1:0] r_index;
  logic                   r_we;
  logic                   hit;
  laddr_t                 req_la;
  logic                   addr_offset_unused;

  assign req_la             = req_addr;
  assign addr_offset_unused = ^req_la.offset;
  assign hit                = oh_doutb.valid && (oh_doutb.tag == r_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= INIT;
      sweep_cnt         <= '0;
      init_done         <= 1'b0;
      r_tag             <= '0;
      r_index           <= '0;
      r_we              <= 1'b0;
      resp_hit          <= 1'b0;
      resp_victim_valid <= 1'b0;
      resp_victim_dirty <= 1'b0;
      resp_victim_tag   <= '0;
      resp_index        <= '0;
    end else begin
      state <= state_nx;
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_INDEX) init_done <= 1'b1;
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            r_tag   <= req_la.tag;
            r_index <= req_la.index;
            r_we    <= req_we;
          end
        end
        READ: begin
          resp_hit          <= hit;
          resp_victim_valid <= oh_doutb.valid;
          resp_victim_dirty <= oh_doutb.dirty;
          resp_victim_tag   <= oh_doutb.tag;
          resp_index        <= r_index;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    fill_ready = 1'b0;
    resp_valid = 1'b0;
    oh_ena     = 1'b0;
    oh_addra   = '0;
    oh_dina    = '0;
    oh_enb     = 1'b0;
    oh_addrb   = '0;

    case (state)
      INIT: begin
        // Hold the write port quiet while reset is still asserted.
        oh_ena   = rst_n;
        oh_addra = sweep_cnt;
        if (sweep_cnt == LAST_INDEX) state_nx = IDLE;
      end
      IDLE: begin
        fill_ready = 1'b1;
        req_ready  = !fill_valid;
        if (fill_valid) begin
          oh_ena        = 1'b1;
          oh_addra      = fill_index;
          oh_dina.valid = 1'b1;
          oh_dina.dirty = fill_dirty;
          oh_dina.tag   = fill_tag;
        end else if (req_valid) begin
          oh_enb   = 1'b1;
          oh_addrb = req_la.index;
          state_nx = READ;
        end
      end
      READ: begin
        state_nx = RESP;
        if (hit && r_we) begin
          oh_ena        = 1'b1;
          oh_addra      = r_index;
          oh_dina.valid = 1'b1;
          oh_dina.dirty = 1'b1;
          oh_dina.tag   = r_tag;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

endmodule

// File: tb/tb_dcache_tag_lookup.sv
// Bench for dcache_tag_lookup with the overhead RAM model and a result scoreboard.
module tb_dcache_tag_lookup;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_hit, resp_victim_valid, resp_victim_dirty;
  logic [19:0] resp_victim_tag;
  logic [5:0]  resp_index;
  logic        fill_valid = 1'b0;
  logic        fill_ready;
  logic [5:0]  fill_index = '0;
  logic [19:0] fill_tag = '0;
  logic        fill_dirty = 1'b0;
  logic [5:0]  oh_addra, oh_addrb;
  logic        oh_ena, oh_enb;
  overhead_t   oh_dina, oh_doutb;

  always #5 clk = ~clk;

  dcache_tag_lookup dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_victim_valid(resp_victim_valid), .resp_victim_dirty(resp_victim_dirty),
    .resp_victim_tag(resp_victim_tag), .resp_index(resp_index),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_dirty(fill_dirty),
    .oh_addra(oh_addra), .oh_ena(oh_ena), .oh_dina(oh_dina),
    .oh_addrb(oh_addrb), .oh_enb(oh_enb), .oh_doutb(oh_doutb)
  );

  dcache_overhead ram (
    .clk(clk), .addra(oh_addra), .ena(oh_ena), .dina(oh_dina),
    .addrb(oh_addrb), .enb(oh_enb), .doutb(oh_doutb)
  );

  typedef struct {
    logic       hit;
    logic       vv;
    logic       vd;
    logic [19:0] vtag;
    logic [5:0] idx;
  } exp_t;

  exp_t        sbq[$];
  logic        mvalid [64];
  logic        mdirty [64];
  logic [19:0] mtag   [64];
  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = '0;
    end
  endtask

  // Releases rst_n and checks the full invalidate sweep.
  task automatic run_sweep();
    int cycles = 0;
    int bad = 0;
    rst_n = 1'b1;
    #1;
    while (!init_done && cycles < 200) begin
      if (cycles >= 64 || oh_ena !== 1'b1 || oh_addra !== 6'(cycles) || oh_dina !== '0 ||
          req_ready !== 1'b0 || fill_ready !== 1'b0) begin
        if (bad == 0)
          $display("FAIL sweep_cycle: cycle %0d ena=%b addra=%0d dina=%h", cycles, oh_ena, oh_addra, oh_dina);
        bad++;
      end
      @(posedge clk); @(negedge clk); #1;
      cycles++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sweep_writes: %0d bad cycles, required 0", bad); end
    checks++;
    if (cycles !== 64) begin errors++; $display("FAIL init_latency: got %0d cycles, required 64", cycles); end
    checks++;
    if (oh_ena !== 1'b0 || fill_ready !== 1'b1) begin
      errors++; $display("FAIL idle_after_init: ena=%b fill_ready=%b, required 0/1", oh_ena, fill_ready);
    end
    model_clear();
  endtask

  // Issues one lookup; returns at the negedge where resp_valid must first be high.
  task automatic issue_req(input logic [31:0] addr, input logic we, output int waited);
    exp_t e;
    logic [5:0]  idx;
    logic [19:0] tg;
    logic        wr;
    idx = addr[11:6];
    tg  = addr[31:12];
    req_valid = 1'b1; req_addr = addr; req_we = we;
    waited = 0;
    #1;
    while (req_ready !== 1'b1 && waited < 20) begin @(negedge clk); #1; waited++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_handshake: req_ready=%b after %0d cycles, required 1", req_ready, waited);
      req_valid = 1'b0;
      return;
    end
    checks++;
    if (oh_enb !== 1'b1 || oh_addrb !== idx) begin
      errors++; $display("FAIL read_issue: enb=%b addrb=%0d, required 1/%0d", oh_enb, oh_addrb, idx);
    end
    e.hit = mvalid[idx] && (mtag[idx] == tg);
    e.vv = mvalid[idx]; e.vd = mdirty[idx]; e.vtag = mtag[idx]; e.idx = idx;
    sbq.push_back(e);
    wr = e.hit && we;
    if (wr) mdirty[idx] = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_early: resp_valid=%b at T+1, required 0", resp_valid); end
    checks++;
    if (oh_ena !== wr || (wr && (oh_addra !== idx || oh_dina !== {1'b1, 1'b1, tg}))) begin
      errors++;
      $display("FAIL store_hit_write: ena=%b addra=%0d dina=%h, required ena=%b addra=%0d dina=%h",
               oh_ena, oh_addra, oh_dina, wr, idx, {1'b1, 1'b1, tg});
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_latency: resp_valid=%b at T+2, required 1", resp_valid); end
  endtask

  task automatic take_resp();
    exp_t e;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (sbq.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty: size 0, required >0");
    end else begin
      e = sbq.pop_front();
      if (resp_valid !== 1'b1 || resp_hit !== e.hit || resp_victim_valid !== e.vv ||
          resp_victim_dirty !== e.vd || resp_victim_tag !== e.vtag || resp_index !== e.idx) begin
        errors++;
        $display("FAIL resp_fields: got v=%b hit=%b vv=%b vd=%b vtag=%h idx=%0d, required v=1 hit=%b vv=%b vd=%b vtag=%h idx=%0d",
                 resp_valid, resp_hit, resp_victim_valid, resp_victim_dirty, resp_victim_tag, resp_index,
                 e.hit, e.vv, e.vd, e.vtag, e.idx);
      end
    end
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL resp_release: resp_valid=%b req_ready=%b, required 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic do_fill(input logic [5:0] idx, input logic [19:0] tg, input logic d);
    fill_valid = 1'b1; fill_index = idx; fill_tag = tg; fill_dirty = d;
    #1;
    checks++;
    if (fill_ready !== 1'b1 || oh_ena !== 1'b1 || oh_addra !== idx || oh_dina !== {1'b1, d, tg}) begin
      errors++;
      $display("FAIL fill_write: ready=%b ena=%b addra=%0d dina=%h, required 1/1/%0d/%h",
               fill_ready, oh_ena, oh_addra, oh_dina, idx, {1'b1, d, tg});
    end
    @(posedge clk);
    mvalid[idx] = 1'b1; mdirty[idx] = d; mtag[idx] = tg;
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({init_done, req_ready, resp_valid, fill_ready, oh_ena, oh_enb} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: done=%b rq=%b rv=%b fr=%b ena=%b enb=%b, required all 0",
               init_done, req_ready, resp_valid, fill_ready, oh_ena, oh_enb);
    end
    checks++;
    if ({resp_hit, resp_victim_valid, resp_victim_dirty, resp_victim_tag, resp_index} !== 29'b0) begin
      errors++; $display("FAIL reset_fields: got %h, required 0",
                         {resp_hit, resp_victim_valid, resp_victim_dirty, resp_victim_tag, resp_index});
    end
    run_sweep();
  endtask

  task automatic test_load_miss();
    int w;
    issue_req(32'h0000_1040, 1'b0, w);
    take_resp();
  endtask

  task automatic test_fill_and_hits();
    int w;
    do_fill(6'd1, 20'h00001, 1'b0);
    issue_req(32'h0000_1048, 1'b0, w); take_resp();
    issue_req(32'h0000_1040, 1'b1, w); take_resp();
    issue_req(32'h0000_2040, 1'b0, w); take_resp();
  endtask

  task automatic test_priority();
    int w;
    fill_valid = 1'b1; fill_index = 6'd2; fill_tag = 20'h00003; fill_dirty = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_3080; req_we = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || fill_ready !== 1'b1 || oh_ena !== 1'b1 || oh_addra !== 6'd2 || oh_enb !== 1'b0) begin
      errors++;
      $display("FAIL fill_priority: req_ready=%b fill_ready=%b ena=%b addra=%0d enb=%b, required 0/1/1/2/0",
               req_ready, fill_ready, oh_ena, oh_addra, oh_enb);
    end
    @(posedge clk);
    mvalid[2] = 1'b1; mdirty[2] = 1'b0; mtag[2] = 20'h00003;
    @(negedge clk);
    fill_valid = 1'b0;
    issue_req(32'h0000_3080, 1'b0, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL req_after_fill: waited %0d cycles, required 0", w); end
    take_resp();
  endtask

  task automatic test_stall();
    int w;
    int bad = 0;
    issue_req(32'h0000_3080, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || sbq.size() == 0 ||
          resp_hit !== sbq[0].hit || resp_victim_valid !== sbq[0].vv || resp_victim_dirty !== sbq[0].vd ||
          resp_victim_tag !== sbq[0].vtag || resp_index !== sbq[0].idx) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles, required 0", bad); end
    take_resp();
  endtask

  task automatic test_back_to_back();
    int w;
    logic [5:0]  idx;
    logic [19:0] tg;
    for (int i = 0; i < 10; i++) begin
      idx = 6'($urandom_range(8, 11));
      tg  = 20'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) do_fill(idx, tg, 1'($urandom_range(0, 1)));
      issue_req({tg, idx, 6'($urandom_range(0, 63))}, 1'($urandom_range(0, 1)), w);
      take_resp();
    end
  endtask

  task automatic test_reset_in_resp();
    int w;
    do_fill(6'd5, 20'h00007, 1'b1);
    issue_req(32'h0000_7140, 1'b0, w);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || oh_ena !== 1'b0) begin
      errors++; $display("FAIL reset_abort: resp_valid=%b init_done=%b ena=%b, required 0/0/0",
                         resp_valid, init_done, oh_ena);
    end
    sbq.delete();
    run_sweep();
    @(negedge clk);
    issue_req(32'h0000_7140, 1'b0, w);
    take_resp();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_miss();
    test_fill_and_hits();
    test_priority();
    test_stall();
    test_back_to_back();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
